// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor. Each stage resolves one BLOCK_WIDTH group
// and registers that group's carry into the next stage. Valid/ready on both ends.
module pipelined_cla_adder #(
  parameter int BUS_WIDTH   = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] s,
  output logic                 cout,
  output logic                 overflow
);
  localparam int NUM_BLOCKS = BUS_WIDTH / BLOCK_WIDTH;
  localparam int BW         = BLOCK_WIDTH;

  // Handshake: a beat transfers on a rising edge where valid && ready are both high. A
  // producer holds valid and payload steady while ready is low. The whole pipe moves on
  // adv, so bubbles shift like data and a stalled output freezes every stage.
  logic                 adv;
  logic [BUS_WIDTH-1:0] b_eff;
  logic                 cin_eff;

  always_comb begin
    adv     = !out_valid || out_ready;
    b_eff   = sub ? ~in2 : in2;
    cin_eff = sub ? 1'b1 : cin;
  end

  assign in_ready = adv;

  // Every carry is a flat sum of products of g/p and the group carry-in.
  function automatic logic [BW:0] cla_carries(input logic [BW-1:0] p,
                                               input logic [BW-1:0] g,
                                               input logic          c0);
    logic [BW:0] c;
    logic        term;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= BW; i++) begin
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  genvar k;
  generate
    for (k = 0; k < NUM_BLOCKS; k++) begin : stg
      localparam int REM = BUS_WIDTH - k * BW;
      localparam int LO  = (k + 1) * BW;

      logic [REM-1:0] a_in;
      logic [REM-1:0] b_in;
      logic           c_in;
      logic           v_in;
      logic [LO-1:0]  lo_in;
      logic [BW-1:0]  p;
      logic [BW-1:0]  g;
      logic [BW:0]    c;
      logic           vld_d, vld_q;
      logic           c_d, c_q;
      logic [LO-1:0]  sum_d, sum_q;

      if (k == 0) begin : src
        always_comb begin
          a_in  = in1;
          b_in  = b_eff;
          c_in  = cin_eff;
          v_in  = in_valid;
          lo_in = '0;
        end
      end else begin : src
        always_comb begin
          a_in  = stg[k-1].opr.opa_q;
          b_in  = stg[k-1].opr.opb_q;
          c_in  = stg[k-1].c_q;
          v_in  = stg[k-1].vld_q;
          lo_in = {{BW{1'b0}}, stg[k-1].sum_q};
        end
      end

      always_comb begin
        p     = a_in[BW-1:0] ^ b_in[BW-1:0];
        g     = a_in[BW-1:0] & b_in[BW-1:0];
        c     = cla_carries(p, g, c_in);
        vld_d = vld_q;
        c_d   = c_q;
        sum_d = sum_q;
        if (adv) begin
          vld_d             = v_in;
          c_d               = c[BW];
          sum_d             = lo_in;
          sum_d[k*BW +: BW] = p ^ c[BW-1:0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          sum_q <= '0;
        end else begin
          vld_q <= vld_d;
          c_q   <= c_d;
          sum_q <= sum_d;
        end
      end

      // Operand bits not yet consumed travel alongside the partial sum.
      if (k < NUM_BLOCKS - 1) begin : opr
        logic [REM-BW-1:0] opa_d, opa_q;
        logic [REM-BW-1:0] opb_d, opb_q;

        always_comb begin
          opa_d = opa_q;
          opb_d = opb_q;
          if (adv) begin
            opa_d = a_in[REM-1:BW];
            opb_d = b_in[REM-1:BW];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
          end else begin
            opa_q <= opa_d;
            opb_q <= opb_d;
          end
        end
      end

      if (k == NUM_BLOCKS - 1) begin : fin
        logic ovf_d, ovf_q;

        always_comb begin
          ovf_d = ovf_q;
          if (adv) ovf_d = c[BW-1] ^ c[BW];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) ovf_q <= 1'b0;
          else        ovf_q <= ovf_d;
        end
      end
    end
  endgenerate

  assign out_valid = stg[NUM_BLOCKS-1].vld_q;
  assign s         = stg[NUM_BLOCKS-1].sum_q;
  assign cout      = stg[NUM_BLOCKS-1].c_q;
  assign overflow  = stg[NUM_BLOCKS-1].fin.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at 16/4: carry ripple, subtract, back-pressure,
// mid-stream reset, plus a short random-out_ready run against an arithmetic model.
module tb_pipelined_cla_adder;
  localparam int W  = 16;
  localparam int BW = 4;
  localparam int NB = W / BW;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic         cin;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         overflow;

  // Expected entries are {cout, overflow, s}.
  logic [W+1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  bit           stream_done;

  pipelined_cla_adder #(.BUS_WIDTH(W), .BLOCK_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Clock / reset block: posedges at 5,15,..; inputs change on negedges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sb, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] bx;
    logic         ovf;
    bx   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], ovf, full[W-1:0]};
  endfunction

  // Driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                      input logic ci, input logic [W+1:0] exp);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    sub      = sb;
    cin      = ci;
    #4;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", guard, 0);
    else exp_q.push_back(exp);
  endtask

  task automatic send_rand();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sb;
    logic         ci;
    a  = W'($urandom);
    b  = W'($urandom);
    sb = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    send(a, b, sb, ci, model(a, b, sb, ci));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in1      = W'($urandom);
    in2      = W'($urandom);
  endtask

  task automatic lat(input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk(tag, n, NB);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: samples 1 time unit before each posedge.
  logic [W+2:0] prev_out;
  logic         prev_stall;

  initial begin
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (prev_stall) chk("hold", {out_valid, cout, overflow, s}, prev_out);
        if (out_valid && out_ready) begin
          chk("queue_nonempty", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("result", {cout, overflow, s}, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, cout, overflow, s};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    logic seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    sub         = 1'b0;
    cin         = 1'b0;
    in1         = '0;
    in2         = '0;
    out_ready   = 1'b1;
    stream_done = 1'b0;

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in1      = W'($urandom);
      in2      = W'($urandom);
      sub      = 1'($urandom_range(0, 1));
      cin      = 1'($urandom_range(0, 1));
      #4;
      chk("reset_out", {out_valid, cout, overflow, s}, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #4;
    chk("in_ready_after_reset", in_ready, 1);

    // Directed vectors, each checked for value and latency.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h20000);
    lat("lat_ffff_p1");
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000);
    lat("lat_7fff_p1");
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF);
    lat("lat_8000_m1");
    send(16'h0003, 16'h0005, 1'b1, 1'b0, 18'h0FFFE);
    lat("lat_3_m5");
    send(16'h00FF, 16'h0000, 1'b0, 1'b1, 18'h00100);
    lat("lat_cin_ripple");
    send(16'h0005, 16'h0005, 1'b1, 1'b0, 18'h20000);
    lat("lat_5_m5");
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    lat("lat_neg_ovf");
    drain("drain_directed");

    // Back-pressure: 10 back-to-back beats, out_ready low in cycles 6..8.
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
        idle();
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          out_ready = !(c >= 6 && c <= 8);
          if (c >= 6 && c <= 8) begin
            #4;
            chk("stall_in_ready", in_ready, 0);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Random beats under random out_ready.
    fork
      begin
        for (int i = 0; i < 30; i++) send_rand();
        idle();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    // Mid-stream reset discards in-flight beats.
    send_rand();
    send_rand();
    send_rand();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #4;
      if (out_valid) seen = 1'b1;
    end
    chk("no_ghost_after_reset", seen, 0);
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345);
    lat("lat_after_reset");
    drain("drain_final");

    repeat (6) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
